sub_seg_pipe: RTL

SUB_SEG_PIPE -- requirements
Module: sub_seg_pipe

---
 rtl/sub_seg_pipe_pkg.sv | 17 +
 rtl/sub_seg_pipe_if.sv | 23 ++
 rtl/sub_seg_pipe_stage.sv | 44 ++++
 rtl/sub_seg_pipe.sv | 122 ++++++++++++
 4 files changed

// File: rtl/sub_seg_pipe_pkg.sv
// Shared sizing helpers for the segmented subtract pipeline.
// Segment count, latency and top-segment width derive from the operand width.
package sub_seg_pkg;

    function automatic int nseg_f(input int w, input int s);
        return (w + s - 1) / s;
    endfunction

    function automatic int lat_f(input int w, input int s);
        return nseg_f(w, s) + 1;
    endfunction

    function automatic int top_w_f(input int w, input int s);
        return (w % s == 0) ? s : (w % s);
    endfunction

endpackage

// File: rtl/sub_seg_pipe_if.sv
// Operand/result bundle for the segmented subtract pipeline.
// master drives operands, slave returns the difference and flags.
interface sub_seg_pipe_if #(
    parameter int IN_WIDTH = 254
);
    logic                       in_valid;
    logic signed [IN_WIDTH-1:0] A;
    logic signed [IN_WIDTH-1:0] B;
    logic signed [IN_WIDTH:0]   D;
    logic                       lt;
    logic                       eq;
    logic                       out_valid;

    modport master (
        output in_valid, A, B,
        input  D, lt, eq, out_valid
    );

    modport slave (
        input  in_valid, A, B,
        output D, lt, eq, out_valid
    );
endinterface

// File: rtl/sub_seg_pipe_stage.sv
// One registered subtract segment: a - b - borrow_in.
// Emits the segment difference, borrow_out and a running zero flag.
module sub_seg_stage #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         bin_i,
    input  logic         zin_i,
    output logic [W-1:0] d_o,
    output logic         bout_o,
    output logic         z_o
);
    logic [W:0]   diff;
    logic [W-1:0] d_d, d_q;
    logic         bout_d, bout_q;
    logic         z_d, z_q;

    // The extra MSB of the widened difference is the borrow out
    always_comb begin
        diff   = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bin_i};
        d_d    = diff[W-1:0];
        bout_d = diff[W];
        z_d    = zin_i & (diff[W-1:0] == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q    <= '0;
            bout_q <= 1'b0;
            z_q    <= 1'b0;
        end else begin
            d_q    <= d_d;
            bout_q <= bout_d;
            z_q    <= z_d;
        end
    end

    assign d_o    = d_q;
    assign bout_o = bout_q;
    assign z_o    = z_q;
endmodule

// File: rtl/sub_seg_pipe.sv
// Signed A-B with a borrow-chained, segment-per-stage pipeline.
// Operands are skewed in, results deskewed out, so throughput is one pair per cycle.
module sub_seg_pipe
    import sub_seg_pkg::*;
#(
    parameter int IN_WIDTH    = 254,
    parameter int STAGE_WIDTH = 64
) (
    input  logic           clk,
    input  logic           reset,
    sub_seg_pipe_if.slave  bus
);
    localparam int NSEG = nseg_f(IN_WIDTH, STAGE_WIDTH);
    localparam int LAT  = lat_f(IN_WIDTH, STAGE_WIDTH);
    localparam int TW   = top_w_f(IN_WIDTH, STAGE_WIDTH);

    logic [IN_WIDTH-1:0] a_q, b_q;
    logic [LAT-1:0]      v_d, v_q;
    logic [NSEG-1:0]     bw;
    logic [NSEG-1:0]     zw;
    logic [IN_WIDTH:0]   d_all;
    logic                eq_w;
    logic                top_bout_unused;

    always_ff @(posedge clk) begin
        a_q <= bus.A;
        b_q <= bus.B;
    end

    always_comb v_d = {v_q[LAT-2:0], bus.in_valid};

    always_ff @(posedge clk) begin
        if (reset) v_q <= '0;
        else       v_q <= v_d;
    end

    assign bw[0] = 1'b0;
    assign zw[0] = 1'b1;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam bit IS_TOP = (k == NSEG - 1);
        localparam int SW     = IS_TOP ? TW : STAGE_WIDTH;
        localparam int W      = IS_TOP ? TW + 1 : STAGE_WIDTH;
        localparam int LO     = k * STAGE_WIDTH;
        localparam int DLY    = NSEG - 1 - k;

        logic [SW-1:0] a_k, b_k;
        logic [W-1:0]  a_s, b_s, d_s;
        logic          bout, z;

        if (k == 0) begin : g_nosk
            assign a_k = a_q[LO +: SW];
            assign b_k = b_q[LO +: SW];
        end else begin : g_sk
            logic [SW-1:0] a_sk_q [k];
            logic [SW-1:0] b_sk_q [k];

            always_ff @(posedge clk) begin
                a_sk_q[0] <= a_q[LO +: SW];
                b_sk_q[0] <= b_q[LO +: SW];
                for (int j = 1; j < k; j++) begin
                    a_sk_q[j] <= a_sk_q[j-1];
                    b_sk_q[j] <= b_sk_q[j-1];
                end
            end

            assign a_k = a_sk_q[k-1];
            assign b_k = b_sk_q[k-1];
        end

        // Top segment carries one sign-extension bit, so D never overflows
        if (IS_TOP) begin : g_ext
            assign a_s = {a_k[SW-1], a_k};
            assign b_s = {b_k[SW-1], b_k};
        end else begin : g_noext
            assign a_s = a_k;
            assign b_s = b_k;
        end

        sub_seg_stage #(.W(W)) u_stage (
            .clk    (clk),
            .reset  (reset),
            .a_i    (a_s),
            .b_i    (b_s),
            .bin_i  (bw[k]),
            .zin_i  (zw[k]),
            .d_o    (d_s),
            .bout_o (bout),
            .z_o    (z)
        );

        if (IS_TOP) begin : g_top
            assign eq_w            = z;
            assign top_bout_unused = bout;
        end else begin : g_chain
            assign bw[k+1] = bout;
            assign zw[k+1] = z;
        end

        if (DLY == 0) begin : g_nodsk
            assign d_all[LO +: W] = d_s;
        end else begin : g_dsk
            logic [W-1:0] dk_q [DLY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < DLY; j++) dk_q[j] <= '0;
                end else begin
                    dk_q[0] <= d_s;
                    for (int j = 1; j < DLY; j++) dk_q[j] <= dk_q[j-1];
                end
            end

            assign d_all[LO +: W] = dk_q[DLY-1];
        end
    end

    assign bus.D         = d_all;
    assign bus.lt        = d_all[IN_WIDTH];
    assign bus.eq        = eq_w;
    assign bus.out_valid = v_q[LAT-1];
endmodule
